// File: rtl/shift_burst_ctrl_pkg.sv
// Shared definitions for the shift/burst controller: FSM encoding, burst length, blank segment code.
// Latency: n/a (types, constants and a pure BCD increment helper).
// Backpressure: n/a.
package shift_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned BURST_LEN = 9;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Two-digit BCD increment {tens, units}; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    logic [3:0] units;
    logic [3:0] tens;
    units = bcd[3:0];
    tens  = bcd[7:4];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/hex7seg.sv
// 4-bit value to active-low 7-segment pattern (bit order gfedcba).
// Latency: purely combinational.
// Backpressure: none.
module hex7seg
  import shift_burst_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // table lookup of the segment pattern for each hex digit
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every DIV cycles while not cleared.
// Latency: first tick is DIV cycles after clear drops (counter restarts from 0).
// Backpressure: none; clear holds the counter at 0 and masks the tick.
module tick_gen #(
  parameter int unsigned DIV = 5_000_000
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int unsigned  W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // count 0..DIV-1 and wrap; clear forces the count back to 0
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/shift_burst_ctrl.sv
// Manual / timed-burst shift register with BCD parity-event counter and 7-segment status.
// Latency: press acts 3 cycles after KEY[0] is sampled low; burst shifts every TICK_DIV cycles.
// Backpressure: none; presses during DONE are dropped, a press during SHIFT aborts the burst.
module shift_burst_ctrl
  import shift_burst_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2
);

  localparam logic [3:0] REM_FULL = 4'(BURST_LEN);

  logic       rst_n;
  logic       key_s1, key_s2, key_d, press;
  state_t     state, state_nxt;
  logic [9:0] led;
  logic [8:0] pat;
  logic [3:0] remaining;
  logic [7:0] count;
  logic       tick, tick_clear;
  logic       load, manual_shift, burst_shift, do_shift, shift_in;
  logic [6:0] hex2_digit;

  assign rst_n = KEY[1];

  // synchronise the active-low button and register a one-cycle pulse on its press edge
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
      key_d  <= 1'b0;
      press  <= 1'b0;
    end else begin
      key_s1 <= ~KEY[0];
      key_s2 <= key_s1;
      key_d  <= key_s2;
      press  <= key_s2 & ~key_d;
    end
  end

  // prescaler runs only inside a burst, so each burst starts a fresh tick period
  assign tick_clear = !rst_n || (state != ST_SHIFT);

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (CLOCK_50),
    .clear (tick_clear),
    .tick  (tick)
  );

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and shift controls; an abort press outranks a coincident tick
  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    manual_shift = 1'b0;
    burst_shift  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (press) begin
          if (SW[9]) begin
            load      = 1'b1;
            state_nxt = ST_SHIFT;
          end else begin
            manual_shift = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (press) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          burst_shift = 1'b1;
          if (remaining == 4'd1) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign do_shift = manual_shift | burst_shift;
  assign shift_in = burst_shift ? pat[8] : SW[0];

  // datapath: pattern/remaining bookkeeping, LED shift and parity-event counter
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      led       <= '0;
      pat       <= '0;
      remaining <= '0;
      count     <= '0;
    end else begin
      if (load) begin
        pat       <= SW[8:0];
        remaining <= REM_FULL;
      end else if (burst_shift) begin
        pat       <= {pat[7:0], 1'b0};
        remaining <= remaining - 4'd1;
      end
      if (do_shift) begin
        led <= {led[8:0], shift_in};
        if (^led) begin
          count <= bcd_inc(count);
        end
      end
    end
  end

  assign LEDR = led;

  hex7seg u_hex0 (.digit(count[3:0]), .seg(HEX0));
  hex7seg u_hex1 (.digit(count[7:4]), .seg(HEX1));
  hex7seg u_hex2 (.digit(remaining),  .seg(hex2_digit));

  assign HEX2 = (state == ST_SHIFT) ? hex2_digit : SEG_BLANK;

endmodule

// File: tb/tb_shift_burst_ctrl.sv
// Scoreboarded bench for shift_burst_ctrl with a 4-cycle burst tick.
// Expected output snapshots are queued by the stimulus; the monitor pops one per output change.
// Snapshot spacing is also checked where the tick period fixes it.
module tb_shift_burst_ctrl;
  import shift_burst_ctrl_pkg::*;

  localparam int unsigned TDIV = 4;

  logic       clk = 1'b0;
  logic [1:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2;

  shift_burst_ctrl #(.TICK_DIV(TDIV)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .SW       (sw),
    .LEDR     (ledr),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] led;
    logic [6:0] h0;
    logic [6:0] h1;
    logic [6:0] h2;
    int         gap;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   chk_req = 1'b0;
  int   cyc = 0;
  int   last_chg = 0;

  // pattern 1_101010101 burst: LEDR and count after each of the 9 ticks
  logic [9:0] burst_led [9] = '{10'b0000000001, 10'b0000000010, 10'b0000000101,
                                10'b0000001010, 10'b0000010101, 10'b0000101010,
                                10'b0001010101, 10'b0010101010, 10'b0101010101};
  int         burst_cnt [9] = '{0, 1, 2, 2, 2, 3, 4, 4, 4};

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // queue a snapshot; rem < 0 means HEX2 blank; identical consecutive snapshots produce no change
  task automatic push(input logic [9:0] led, input int cnt, input int rem, input int gap, input int tag);
    exp_t e;
    e.led = led;
    e.h0  = seg(cnt % 10);
    e.h1  = seg(cnt / 10);
    e.h2  = seg(rem);
    e.gap = gap;
    e.tag = tag;
    if (e.led != last_exp.led || e.h0 != last_exp.h0 || e.h1 != last_exp.h1 || e.h2 != last_exp.h2)
      exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int low_cyc);
    key[0] = 1'b0;
    step(low_cyc);
    key[0] = 1'b1;
    step(8);
  endtask

  task automatic do_reset();
    key[1] = 1'b0;
    step(3);
    key[1] = 1'b1;
    step(2);
  endtask

  // returns at the falling edge just after the burst has been entered
  task automatic wait_entry(input int tag);
    int i;
    i = 0;
    while (hex2 == SEG_BLANK && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (hex2 == SEG_BLANK) begin
      n_cmp++;
      n_err++;
      $display("FAIL entry_timeout tag=%0d HEX2=%h after %0d cycles, want a digit", tag, hex2, i);
    end
  endtask

  // monitor: compare the next queued snapshot whenever any output changes
  initial begin : monitor
    logic [30:0] prev, cur;
    exp_t e;
    int g;
    prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {ledr, hex0, hex1, hex2};
      if (mon_en && (cur != prev || chk_req)) begin
        chk_req  = 1'b0;
        g        = cyc - last_chg;
        last_chg = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change LEDR=%b HEX1=%h HEX0=%h HEX2=%h, want no change",
                   ledr, hex1, hex0, hex2);
        end else begin
          e = exp_q.pop_front();
          if (ledr != e.led || hex0 != e.h0 || hex1 != e.h1 || hex2 != e.h2) begin
            n_err++;
            $display("FAIL snap tag=%0d got LEDR=%b HEX1=%h HEX0=%h HEX2=%h want LEDR=%b HEX1=%h HEX0=%h HEX2=%h",
                     e.tag, ledr, hex1, hex0, hex2, e.led, e.h1, e.h0, e.h2);
          end
          if (e.gap > 0) begin
            n_cmp++;
            if (g != e.gap) begin
              n_err++;
              $display("FAIL gap tag=%0d got %0d cycles want %0d", e.tag, g, e.gap);
            end
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout, bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [9:0] mled;
    int         mcnt;
    logic       b;

    key = 2'b01;
    sw  = '0;
    last_exp.led = '1;
    last_exp.h0  = '0;
    last_exp.h1  = '0;
    last_exp.h2  = '0;
    last_exp.gap = 0;
    last_exp.tag = 0;

    // reset state while KEY[1] is held low
    step(4);
    push(10'd0, 0, -1, 0, 1);
    mon_en  = 1'b1;
    chk_req = 1'b1;
    step(1);
    key[1] = 1'b1;
    step(3);

    // three manual shifts of 1
    sw = 10'b0_000000001;
    push(10'b0000000001, 0, -1, 0, 2);
    push(10'b0000000011, 1, -1, 0, 3);
    push(10'b0000000111, 1, -1, 0, 4);
    press(2);
    press(2);
    press(2);

    // key held for 100 cycles gives one shift (of 0, parity before is odd)
    sw = 10'b0_000000000;
    push(10'b0000001110, 2, -1, 0, 5);
    key[0] = 1'b0;
    step(100);
    key[0] = 1'b1;
    step(10);

    // full burst, SW changed mid-burst, then a manual shift proves return to idle
    push(10'd0, 0, -1, 0, 6);
    do_reset();
    sw = 10'b1_101010101;
    push(10'd0, 0, 9, 0, 7);
    for (int i = 0; i < 9; i++)
      push(burst_led[i], burst_cnt[i], (i == 8) ? -1 : 8 - i, TDIV, 10 + i);
    push(10'b1010101011, 5, -1, 0, 20);
    key[0] = 1'b0;
    wait_entry(7);
    @(posedge clk);
    #1;
    key[0] = 1'b1;
    step(6);
    sw = 10'b0_000000000;
    step(45);
    sw = 10'b0_000000001;
    press(2);

    // abort after the third tick
    push(10'd0, 0, -1, 0, 30);
    do_reset();
    sw = 10'b1_101010101;
    push(10'd0, 0, 9, 0, 31);
    for (int i = 0; i < 3; i++)
      push(burst_led[i], burst_cnt[i], 8 - i, TDIV, 32 + i);
    push(10'b0000000101, 2, -1, 0, 35);
    key[0] = 1'b0;
    wait_entry(31);
    @(posedge clk);
    #1;
    key[0] = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    key[0] = 1'b0;
    step(3);
    key[0] = 1'b1;
    step(30);

    // reset on the same cycle as the second tick
    push(10'd0, 0, -1, 0, 40);
    do_reset();
    sw = 10'b1_101010101;
    push(10'd0, 0, 9, 0, 41);
    push(10'b0000000001, 0, 8, TDIV, 42);
    push(10'd0, 0, -1, TDIV, 43);
    key[0] = 1'b0;
    wait_entry(41);
    @(posedge clk);
    #1;
    key[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    key[1] = 1'b0;
    step(3);
    key[1] = 1'b1;
    step(20);

    // count up to 99 with odd-parity shifts, then wrap to 00
    push(10'd0, 0, -1, 0, 50);
    do_reset();
    sw   = '0;
    mled = '0;
    mcnt = 0;
    for (int i = 0; i < 101; i++) begin
      b = (i == 0) ? 1'b1 : mled[9];
      if (^mled) mcnt = (mcnt + 1) % 100;
      mled = {mled[8:0], b};
      push(mled, mcnt, -1, 0, 100 + i);
      sw[0] = b;
      press(2);
    end

    step(10);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover got %0d pending snapshots want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_burst_ctrl.md
SHIFT_BURST_CTRL -- requirements
Module: shift_burst_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 5_000_000; CLOCK_50 cycles per burst shift tick (10 Hz); legal range 2..2^24-1.
REQ-002 SHALL have port CLOCK_50  input  1  system clock; every register updates on its rising edge.
REQ-003 SHALL have port KEY  input  2  pushbuttons, active-low; KEY[1] is the reset, synchronous and active-low; KEY[0] is the request button.
REQ-004 SHALL have port SW  input  10  SW[9] selects mode (0 manual, 1 burst); SW[8:0] is the burst pattern; SW[0] is the manual data bit.
REQ-005 SHALL have port LEDR  output  10  shift register contents, registered.
REQ-006 SHALL have port HEX0  output  7  event count, BCD units digit, active-low segments.
REQ-007 SHALL have port HEX1  output  7  event count, BCD tens digit, active-low segments.
REQ-008 SHALL have port HEX2  output  7  bits remaining in the burst (0..9), active-low segments; all segments off (7'h7F) outside SHIFT.

Function
REQ-009 SHALL pass KEY[0] through a 2-FF synchroniser plus an edge-detect stage, giving a 1-cycle press pulse 3 cycles after KEY[0] is sampled low; a held key gives exactly one pulse.
REQ-010 SHALL implement states IDLE, SHIFT, DONE; next state after reset is IDLE.
REQ-011 IDLE, press, SW[9]=0: SHALL perform one shift in the same cycle, LEDR <= {LEDR[8:0], SW[0]}; state stays IDLE.
REQ-012 IDLE, press, SW[9]=1: SHALL capture SW[8:0] into a pattern register, load remaining=9, clear the prescaler, and enter SHIFT.
REQ-013 SHIFT: SHALL assert a tick every TICK_DIV cycles, first tick TICK_DIV cycles after entry; on each tick, LEDR <= {LEDR[8:0], pat[8]}, pat <= pat << 1, remaining decrements by 1.
REQ-014 SHIFT: the tick that brings remaining to 0 SHALL move the FSM to DONE; DONE SHALL last exactly 1 cycle, then return to IDLE.
REQ-015 A press during SHIFT SHALL abort the burst: FSM goes to IDLE next cycle, LEDR keeps its partial contents, and no shift happens in that cycle even if a tick coincides.
REQ-016 A press during DONE SHALL be ignored.
REQ-017 SW changes during SHIFT SHALL NOT affect the burst; the pattern and mode are fixed at entry.
REQ-018 Event rule, for every shift (manual or burst): if ^LEDR == 1 before the shift, the BCD count SHALL increment by 1 in the same cycle as the shift.
REQ-019 The count SHALL be two BCD digits, 00..99; units 9 -> 0 with tens carry; 99 -> 00 on increment.
REQ-020 HEX0, HEX1 and HEX2 SHALL be combinational decodes of registered values, so they have no added latency.

Reset
REQ-021 With KEY[1]=0 at a CLOCK_50 edge, the block SHALL set LEDR=10'd0, count=00, pat=0, remaining=0, prescaler=0, synchroniser and edge-detect registers to 0 (not pressed), and FSM=IDLE.
REQ-022 Reset SHALL take priority over all events, including a tick or press in the same cycle; reset during SHIFT abandons the burst.
REQ-023 While reset is held: HEX0=HEX1=digit "0", HEX2=7'h7F; no press pulse is generated on the cycle reset is released.

Structure
REQ-024 The FSM state encoding and the constants BURST_LEN=9 and SEG_BLANK=7'h7F SHALL be in the shared lab package.
REQ-025 The prescaler SHALL be one sub-module, tick_gen (parameter DIV; ports clk, clear, tick); the 7-seg decoding SHALL reuse the team's existing 4-bit-to-segment decoder, three instances.

Verification (TICK_DIV=4)
REQ-026 Reset, SW[9]=0, SW[0]=1, three presses -> LEDR=10'b0000000111, count=01 (the 3rd shift sees LEDR=0000000011; parity 0 there, parity 1 before the 2nd shift).
REQ-027 Reset, SW=10'b1_101010101, one press -> SHIFT; 9 ticks at 4-cycle spacing; LEDR=10'b0101010101; HEX2 counts 9..1 then blanks; DONE for 1 cycle; count=04.
REQ-028 Burst started, press after the 3rd tick -> IDLE; LEDR=10'b0000000101, HEX2 blank, no further shifts.
REQ-029 Count preset to 99 via 99 odd-parity manual shifts, then one more odd-parity shift -> HEX1/HEX0 show 00.
REQ-030 KEY[1]=0 mid-burst on the same cycle as a tick -> all registers hold their reset values next cycle, and LEDR does not shift.
REQ-031 KEY[0] held low for 100 cycles in manual mode -> exactly one shift.
